curve_rhs_eval: RTL and testbench
=================================

CURVE_RHS_EVAL -- requirements
Module: curve_rhs_eval

Purpose: computes the curve right-hand side rhs = x^3 + A*x + B mod P and rhs^2 mod P for a given x. These outputs drive the radicand and radicand-squared inputs of the downstream modular square-root stage.

Interface
REQ-001 Parameter P SHALL default to 256'd115792089237316195423570985008687907853269984665640564039457584007908834671663; it is the field prime.
REQ-002 Parameter A_COEF SHALL be 256 bits, default 256'd0; it is the curve coefficient a.
REQ-003 Parameter B_COEF SHALL be 256 bits, default 256'd7; it is the curve coefficient b.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 Start  input  1  SHALL be a one-cycle request to evaluate x.
REQ-007 x  input  256  SHALL be the x-coordinate operand, sampled in the cycle Start is accepted.
REQ-008 Busy  output  1  SHALL be high while an evaluation is in progress.
REQ-009 Done  output  1  SHALL be high while rhs and rhs_squared are valid.
REQ-010 rhs  output  256  SHALL be x^3 + A_COEF*x + B_COEF mod P.
REQ-011 rhs_squared  output  256  SHALL be rhs*rhs mod P.

Function
REQ-012 Arithmetic SHALL use one shared instance of the codebase modular multiplier (parameter P, active-high synchronous reset, Done/product handshake) plus combinational modular add.
REQ-013 FSM states SHALL be IDLE, LOAD, OP_SQX, RUN_SQX, OP_CUBE, RUN_CUBE, OP_AX, RUN_AX, ADD_AX, ADD_B, OP_SQR, RUN_SQR, DONE.
REQ-014 IDLE or DONE with Start=1 SHALL go to LOAD; Start in any other state SHALL be ignored.
REQ-015 LOAD SHALL register xr = (x >= P) ? x - P : x; inputs x >= 2P are out of contract.
REQ-016 Each OP_* state SHALL last one cycle, load both multiplier operand registers and hold the multiplier in reset.
REQ-017 Operands SHALL be: OP_SQX xr,xr; OP_CUBE t0,xr; OP_AX A_COEF,xr; OP_SQR s,s.
REQ-018 Each RUN_* state SHALL release the multiplier and remain until multiplier Done=1; in that cycle it SHALL capture the product (t0, t1, t2, rhs_squared respectively) and advance.
REQ-019 If A_COEF == 0, RUN_CUBE SHALL go directly to ADD_AX with t2 = 0; otherwise it SHALL go to OP_AX.
REQ-020 ADD_AX SHALL set s = (t1 + t2) mod P, using a 257-bit sum and one conditional subtract of P.
REQ-021 ADD_B SHALL set s = (s + B_COEF) mod P the same way, then go to OP_SQR.
REQ-022 RUN_SQR completion SHALL load rhs = s and rhs_squared = product in the same edge and enter DONE.
REQ-023 Busy SHALL be 1 in every state except IDLE and DONE.
REQ-024 Done SHALL be 1 only in DONE; rhs and rhs_squared SHALL hold stable until the next accepted Start.
REQ-025 Latency from the Start-accepting edge to Done=1 SHALL be 1 + 4 + 2 + (sum of RUN dwell cycles), with the OP_AX/RUN_AX terms removed when A_COEF == 0.
REQ-026 The multiplier SHALL be held in reset in every state other than RUN_*.

Reset
REQ-027 Reset_n=0 at a rising edge SHALL force IDLE, Busy=0, Done=0, rhs=0, rhs_squared=0 and clear all intermediate registers.
REQ-028 Reset_n=0 mid-evaluation SHALL abort it; no stale result SHALL appear after release.
REQ-029 Start SHALL be ignored in any cycle with Reset_n=0.

Verification
REQ-030 Default parameters, x=0 -> Done with rhs=7, rhs_squared=49.
REQ-031 x=1 -> rhs=8, rhs_squared=64; x=2 -> rhs=15, rhs_squared=225.
REQ-032 x=P-1 -> rhs=6, rhs_squared=36; x=P (reduced in LOAD) -> rhs=7, rhs_squared=49.
REQ-033 A_COEF=3, B_COEF=5, x=2 -> rhs=19, rhs_squared=361; dwell in RUN_AX observed.
REQ-034 Start pulsed while Busy -> ignored, original result unchanged; Reset_n=0 during RUN_CUBE -> IDLE, outputs 0, next Start with x=1 -> rhs=8.
REQ-035 Back-to-back: Start while in DONE with new x=2 -> Done drops the next cycle, later Done with rhs=15.

Source files
------------

// File: rtl/curve_rhs_eval.sv
// Curve right-hand side evaluator: rhs = x^3 + A*x + B mod P and rhs^2 mod P.
// Uses one shared bit-serial modular multiplier and a shared modular adder.
module curve_rhs_mul #(
    parameter logic [255:0] P = 256'd115792089237316195423570985008687907853269984665640564039457584007908834671663
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         done,
    output logic [255:0] product
);
    logic [7:0]   r_cnt;
    logic [255:0] r_acc;
    logic         r_done;
    logic [256:0] w_dbl;
    logic [255:0] w_dbl_red;
    logic [256:0] w_sum;
    logic [255:0] w_sum_red;
    logic         w_bit;

    // MSB-first interleaved multiply: acc = 2*acc (+ b) each step, kept < P
    assign w_bit     = a[~r_cnt];
    assign w_dbl     = {r_acc, 1'b0};
    assign w_dbl_red = (w_dbl >= {1'b0, P}) ? 256'(w_dbl - {1'b0, P}) : w_dbl[255:0];
    assign w_sum     = {1'b0, w_dbl_red} + {1'b0, b};
    assign w_sum_red = (w_sum >= {1'b0, P}) ? 256'(w_sum - {1'b0, P}) : w_sum[255:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 8'd0;
            r_acc  <= 256'd0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_acc <= w_bit ? w_sum_red : w_dbl_red;
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'd255)
                r_done <= 1'b1;
        end
    end

    assign done    = r_done;
    assign product = r_acc;
endmodule

module curve_rhs_eval #(
    parameter logic [255:0] P = 256'd115792089237316195423570985008687907853269984665640564039457584007908834671663,
    parameter logic [255:0] A_COEF = 256'd0,
    parameter logic [255:0] B_COEF = 256'd7
) (
    input  logic         clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [255:0] x,
    output logic         Busy,
    output logic         Done,
    output logic [255:0] rhs,
    output logic [255:0] rhs_squared
);
    typedef enum logic [3:0] {
        IDLE, LOAD, OP_SQX, RUN_SQX, OP_CUBE, RUN_CUBE, OP_AX,
        RUN_AX, ADD_AX, ADD_B, OP_SQR, RUN_SQR, DONE
    } state_t;

    state_t       r_state;
    logic [255:0] r_xr, r_t0, r_t1, r_t2, r_s;
    logic [255:0] r_opa, r_opb, r_rhs, r_rhs_sq;
    logic         r_busy, r_done;

    logic         w_mul_rst, w_mul_done;
    logic [255:0] w_prod, w_xred;
    logic [255:0] w_add_a, w_add_b, w_add_red;
    logic [256:0] w_add_sum;

    assign w_mul_rst = !((r_state == RUN_SQX) || (r_state == RUN_CUBE) ||
                         (r_state == RUN_AX)  || (r_state == RUN_SQR));

    curve_rhs_mul #(.P(P)) u_mul (
        .clk     (clk),
        .rst     (w_mul_rst),
        .a       (r_opa),
        .b       (r_opb),
        .done    (w_mul_done),
        .product (w_prod)
    );

    assign w_xred    = (r_xr >= P) ? r_xr - P : r_xr;
    assign w_add_a   = (r_state == ADD_AX) ? r_t1 : r_s;
    assign w_add_b   = (r_state == ADD_AX) ? r_t2 : B_COEF;
    assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b};
    assign w_add_red = (w_add_sum >= {1'b0, P}) ? 256'(w_add_sum - {1'b0, P})
                                                : w_add_sum[255:0];

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_xr     <= 256'd0;
            r_t0     <= 256'd0;
            r_t1     <= 256'd0;
            r_t2     <= 256'd0;
            r_s      <= 256'd0;
            r_opa    <= 256'd0;
            r_opb    <= 256'd0;
            r_rhs    <= 256'd0;
            r_rhs_sq <= 256'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_xr    <= x;
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_xr    <= w_xred;
                    r_state <= OP_SQX;
                end
                OP_SQX: begin
                    r_opa   <= r_xr;
                    r_opb   <= r_xr;
                    r_state <= RUN_SQX;
                end
                RUN_SQX: if (w_mul_done) begin
                    r_t0    <= w_prod;
                    r_state <= OP_CUBE;
                end
                OP_CUBE: begin
                    r_opa   <= r_t0;
                    r_opb   <= r_xr;
                    r_state <= RUN_CUBE;
                end
                RUN_CUBE: if (w_mul_done) begin
                    r_t1 <= w_prod;
                    if (A_COEF == 256'd0) begin
                        r_t2    <= 256'd0;
                        r_state <= ADD_AX;
                    end else begin
                        r_state <= OP_AX;
                    end
                end
                OP_AX: begin
                    r_opa   <= A_COEF;
                    r_opb   <= r_xr;
                    r_state <= RUN_AX;
                end
                RUN_AX: if (w_mul_done) begin
                    r_t2    <= w_prod;
                    r_state <= ADD_AX;
                end
                ADD_AX: begin
                    r_s     <= w_add_red;
                    r_state <= ADD_B;
                end
                ADD_B: begin
                    r_s     <= w_add_red;
                    r_state <= OP_SQR;
                end
                OP_SQR: begin
                    r_opa   <= r_s;
                    r_opb   <= r_s;
                    r_state <= RUN_SQR;
                end
                RUN_SQR: if (w_mul_done) begin
                    r_rhs    <= r_s;
                    r_rhs_sq <= w_prod;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy        = r_busy;
    assign Done        = r_done;
    assign rhs         = r_rhs;
    assign rhs_squared = r_rhs_sq;
endmodule

// File: tb/tb_curve_rhs_eval.sv
// Bench for curve_rhs_eval: default curve instance plus an A=3, B=5 instance,
// checked against a wide-arithmetic model and hand-computed literals.
module tb_curve_rhs_eval;
    localparam logic [255:0] PR = 256'd115792089237316195423570985008687907853269984665640564039457584007908834671663;
    localparam logic [255:0] A1 = 256'd3;
    localparam logic [255:0] B1 = 256'd5;

    logic         clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         start0 = 1'b0, start1 = 1'b0;
    logic [255:0] x0 = '0, x1 = '0;
    logic         busy0, done0, busy1, done1;
    logic [255:0] rhs0, sq0, rhs1, sq1;

    logic [255:0] exp_r0 = '0, exp_s0 = '0, exp_r1 = '0, exp_s1 = '0;
    int total = 0;
    int bad = 0;
    int lat0 = 0, lat1 = 0, lat = 0, dwell = 0;

    always #5 clk = ~clk;

    curve_rhs_eval u_dut0 (
        .clk(clk), .Reset_n(Reset_n), .Start(start0), .x(x0),
        .Busy(busy0), .Done(done0), .rhs(rhs0), .rhs_squared(sq0)
    );

    curve_rhs_eval #(.A_COEF(A1), .B_COEF(B1)) u_dut1 (
        .clk(clk), .Reset_n(Reset_n), .Start(start1), .x(x1),
        .Busy(busy1), .Done(done1), .rhs(rhs1), .rhs_squared(sq1)
    );

    function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = {256'd0, a} * {256'd0, b};
        p = p % {256'd0, PR};
        return p[255:0];
    endfunction

    function automatic logic [255:0] model_rhs(input logic [255:0] xv,
                                               input logic [255:0] a,
                                               input logic [255:0] b);
        logic [255:0] xr;
        logic [257:0] s;
        xr = (xv >= PR) ? xv - PR : xv;
        s = {2'b0, mm(mm(xr, xr), xr)} + {2'b0, mm(a, xr)} + {2'b0, b};
        s = s % {2'b0, PR};
        return s[255:0];
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic run(input int w, input logic [255:0] xv, output int l);
        @(negedge clk);
        if (w == 0) begin start0 = 1'b1; x0 = xv; end
        else begin start1 = 1'b1; x1 = xv; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (w == 0) begin
            exp_r0 = model_rhs(xv, 256'd0, 256'd7);
            exp_s0 = mm(exp_r0, exp_r0);
        end else begin
            exp_r1 = model_rhs(xv, A1, B1);
            exp_s1 = mm(exp_r1, exp_r1);
        end
        l = 0;
        while (!(w == 0 ? done0 : done1) && l < 5000) begin
            @(negedge clk);
            l++;
        end
        total++;
        if (l >= 5000) begin
            bad++;
            $display("FAIL done_timeout: dut%0d x=%0d waited %0d cycles", w, xv, l);
        end
    endtask

    task automatic main_seq();
        repeat (3) @(negedge clk);
        chk("reset_busy", 256'(busy0), 256'd0);
        chk("reset_done", 256'(done0), 256'd0);
        chk("reset_rhs", rhs0, 256'd0);
        chk("reset_sq", sq0, 256'd0);
        Reset_n = 1'b1;

        run(0, 256'd0, lat0);
        chk("x0_rhs", rhs0, 256'd7);
        chk("x0_sq", sq0, 256'd49);
        dwell = (lat0 - 6) / 3;
        chk("lat_shape", 256'((lat0 - 6) % 3), 256'd0);
        chk("dwell_pos", 256'(dwell > 0), 256'd1);

        run(0, 256'd1, lat);
        chk("x1_rhs", rhs0, 256'd8);
        chk("x1_sq", sq0, 256'd64);
        chk("lat_repeat", 256'(lat), 256'(lat0));
        run(0, 256'd2, lat);
        chk("x2_rhs", rhs0, 256'd15);
        chk("x2_sq", sq0, 256'd225);
        run(0, PR - 256'd1, lat);
        chk("xpm1_rhs", rhs0, 256'd6);
        chk("xpm1_sq", sq0, 256'd36);
        run(0, PR, lat);
        chk("xp_rhs", rhs0, 256'd7);
        chk("xp_sq", sq0, 256'd49);
        run(0, 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0, lat);

        // Start while busy must be ignored
        @(negedge clk);
        start0 = 1'b1; x0 = 256'd2;
        @(negedge clk);
        start0 = 1'b0;
        exp_r0 = 256'd15;
        exp_s0 = 256'd225;
        repeat (10) @(negedge clk);
        start0 = 1'b1; x0 = 256'd5;
        @(negedge clk);
        start0 = 1'b0;
        lat = 0;
        while (!done0 && lat < 5000) begin @(negedge clk); lat++; end
        chk("busy_ign_rhs", rhs0, 256'd15);
        chk("busy_ign_sq", sq0, 256'd225);

        // Back-to-back from DONE
        @(negedge clk);
        start0 = 1'b1; x0 = 256'd1;
        @(negedge clk);
        start0 = 1'b0;
        chk("b2b_done_drop", 256'(done0), 256'd0);
        chk("b2b_busy", 256'(busy0), 256'd1);
        exp_r0 = 256'd8;
        exp_s0 = 256'd64;
        lat = 0;
        while (!done0 && lat < 5000) begin @(negedge clk); lat++; end
        chk("b2b1_rhs", rhs0, 256'd8);
        run(0, 256'd2, lat);
        chk("b2b2_rhs", rhs0, 256'd15);

        // Reset in the middle of RUN_CUBE
        @(negedge clk);
        start0 = 1'b1; x0 = 256'd2;
        @(negedge clk);
        start0 = 1'b0;
        repeat (dwell + 3 + dwell / 2) @(negedge clk);
        Reset_n = 1'b0;
        start0 = 1'b1; x0 = 256'd3;
        @(negedge clk);
        start0 = 1'b0;
        chk("abort_busy", 256'(busy0), 256'd0);
        chk("abort_done", 256'(done0), 256'd0);
        chk("abort_rhs", rhs0, 256'd0);
        chk("abort_sq", sq0, 256'd0);
        @(negedge clk);
        chk("rst_start_ign", 256'(busy0), 256'd0);
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_stale_done", 256'(done0 | busy0), 256'd0);
        end
        run(0, 256'd1, lat);
        chk("post_rst_rhs", rhs0, 256'd8);
        chk("post_rst_sq", sq0, 256'd64);

        // Nonzero A: extra OP_AX + RUN_AX dwell
        run(1, 256'd2, lat1);
        chk("a3_rhs", rhs1, 256'd19);
        chk("a3_sq", sq1, 256'd361);
        chk("a3_latency", 256'(lat1), 256'(lat0 + 1 + dwell));
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (Reset_n) begin
                        if (done0) begin
                            chk("mon0_rhs", rhs0, exp_r0);
                            chk("mon0_sq", sq0, exp_s0);
                        end
                        if (done1) begin
                            chk("mon1_rhs", rhs1, exp_r1);
                            chk("mon1_sq", sq1, exp_s1);
                        end
                        if ((busy0 && done0) || (busy1 && done1))
                            chk("busy_done_excl", 256'd1, 256'd0);
                    end
                end
            end
            begin
                main_seq();
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
